// File: rtl/icache_dm_if.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm_if
// Purpose  : Fetch-bus (ibus) and memory-bus (CBus) signal bundle for icache_dm.
// Revision : 1.0 - initial release
// ============================================================================
interface icache_dm_if;
   logic        ireq_valid;
   logic [31:0] ireq_addr;

   logic        iresp_addr_ok;
   logic        iresp_data_ok;
   logic [31:0] iresp_data;

   logic        icreq_valid;
   logic        icreq_is_write;
   logic [2:0]  icreq_size;
   logic [31:0] icreq_addr;
   logic [7:0]  icreq_strobe;
   logic [63:0] icreq_data;
   logic [3:0]  icreq_len;
   logic [1:0]  icreq_burst;

   logic        icresp_ready;
   logic        icresp_last;
   logic [63:0] icresp_data;

   // master: core + memory side; slave: the cache sitting between them
   modport master (
      output ireq_valid, ireq_addr, icresp_ready, icresp_last, icresp_data,
      input  iresp_addr_ok, iresp_data_ok, iresp_data,
      input  icreq_valid, icreq_is_write, icreq_size, icreq_addr,
      input  icreq_strobe, icreq_data, icreq_len, icreq_burst
   );

   modport slave (
      input  ireq_valid, ireq_addr, icresp_ready, icresp_last, icresp_data,
      output iresp_addr_ok, iresp_data_ok, iresp_data,
      output icreq_valid, icreq_is_write, icreq_size, icreq_addr,
      output icreq_strobe, icreq_data, icreq_len, icreq_burst
   );
endinterface
`default_nettype wire

// File: rtl/icache_dm.sv
`default_nettype none
// ============================================================================
// Module   : icache_dm
// Purpose  : Direct-mapped read-only instruction cache; hits in the request
//            cycle, misses refill a line with one INCR burst, MMIO fetches
//            pass through as single beats. Define ICACHE_PERF_EN for counters.
// Revision : 1.0 - initial release
// ============================================================================
module icache_dm #(
   parameter int NUM_LINES      = 16,
   parameter int WORDS_PER_LINE = 8,
   parameter int UNCACHED_BIT   = 31
) (
   input  wire logic   clk,
   input  wire logic   reset,
   icache_dm_if.slave  bus,
   input  wire logic   flush,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);
   localparam int         c_WORD_W      = $clog2(WORDS_PER_LINE);
   localparam int         c_OFF_W       = c_WORD_W + 3;
   localparam int         c_IDX_W       = $clog2(NUM_LINES);
   localparam int         c_TAG_W       = 32 - c_OFF_W - c_IDX_W;
   localparam logic [2:0] c_MSIZE4      = 3'd2;
   localparam logic [2:0] c_MSIZE8      = 3'd3;
   localparam logic [3:0] c_MLEN1       = 4'd0;
   localparam logic [3:0] c_MLEN_LINE   = 4'(WORDS_PER_LINE - 1);
   localparam logic [1:0] c_BURST_FIXED = 2'd0;
   localparam logic [1:0] c_BURST_INCR  = 2'd1;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_REFILL   = 2'd1,
      S_UNCACHED = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [NUM_LINES-1:0] r_valid;
   logic [c_TAG_W-1:0]   r_tag  [NUM_LINES];
   logic [63:0]          r_data [NUM_LINES][WORDS_PER_LINE];
   logic [31:0]          r_addr;
   logic [c_WORD_W-1:0]  r_beat;
   logic                 r_flush_pend;

   logic [c_IDX_W-1:0]   w_idx;
   logic [c_IDX_W-1:0]   w_fill_idx;
   logic [c_TAG_W-1:0]   w_tag;
   logic [c_WORD_W-1:0]  w_word;
   logic [63:0]          w_hit_word;
   logic                 w_hit;
   logic                 w_miss_start;
   logic                 w_beat_we;
   logic                 w_fill_done;

   assign w_idx      = bus.ireq_addr[c_OFF_W +: c_IDX_W];
   assign w_tag      = bus.ireq_addr[31 -: c_TAG_W];
   assign w_word     = bus.ireq_addr[3 +: c_WORD_W];
   assign w_fill_idx = r_addr[c_OFF_W +: c_IDX_W];
   assign w_hit_word = r_data[w_idx][w_word];
   assign w_hit      = (r_state == S_IDLE) && bus.ireq_valid && bus.ireq_addr[UNCACHED_BIT]
                       && r_valid[w_idx] && (r_tag[w_idx] == w_tag);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next             = r_state;
      w_miss_start       = 1'b0;
      w_beat_we          = 1'b0;
      w_fill_done        = 1'b0;
      bus.iresp_addr_ok  = 1'b0;
      bus.iresp_data_ok  = 1'b0;
      bus.iresp_data     = '0;
      bus.icreq_valid    = 1'b0;
      bus.icreq_is_write = 1'b0;
      bus.icreq_size     = '0;
      bus.icreq_addr     = '0;
      bus.icreq_strobe   = '0;
      bus.icreq_data     = '0;
      bus.icreq_len      = '0;
      bus.icreq_burst    = '0;
      case (r_state)
         S_IDLE: begin
            if (w_hit) begin
               bus.iresp_addr_ok = 1'b1;
               bus.iresp_data_ok = 1'b1;
               bus.iresp_data    = bus.ireq_addr[2] ? w_hit_word[63:32] : w_hit_word[31:0];
            end else if (bus.ireq_valid) begin
               if (bus.ireq_addr[UNCACHED_BIT]) begin
                  w_miss_start = 1'b1;
                  w_next       = S_REFILL;
               end else begin
                  w_next = S_UNCACHED;
               end
            end
         end
         S_REFILL: begin
            bus.icreq_valid = 1'b1;
            bus.icreq_size  = c_MSIZE8;
            bus.icreq_addr  = {r_addr[31:c_OFF_W], {c_OFF_W{1'b0}}};
            bus.icreq_len   = c_MLEN_LINE;
            bus.icreq_burst = c_BURST_INCR;
            if (bus.icresp_ready) begin
               w_beat_we = 1'b1;
               if (bus.icresp_last) begin
                  w_fill_done = 1'b1;
                  w_next      = S_IDLE;
               end
            end
         end
         S_UNCACHED: begin
            bus.icreq_valid = 1'b1;
            bus.icreq_size  = c_MSIZE4;
            bus.icreq_addr  = r_addr;
            bus.icreq_len   = c_MLEN1;
            bus.icreq_burst = c_BURST_FIXED;
            if (bus.icresp_ready) begin
               bus.iresp_addr_ok = 1'b1;
               bus.iresp_data_ok = 1'b1;
               bus.iresp_data    = r_addr[2] ? bus.icresp_data[63:32] : bus.icresp_data[31:0];
               w_next            = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_valid      <= '0;
         r_addr       <= '0;
         r_beat       <= '0;
         r_flush_pend <= 1'b0;
      end else begin
         if (r_state == S_IDLE && bus.ireq_valid) begin
            r_addr <= bus.ireq_addr;
         end
         // The victim line is invalidated up front so a partly overwritten line never hits
         if (w_miss_start) begin
            r_valid[w_idx] <= 1'b0;
            r_beat         <= '0;
         end else if (w_beat_we) begin
            r_beat <= r_beat + 1'b1;
         end
         if (w_fill_done) begin
            r_flush_pend <= 1'b0;
         end else if (r_state == S_REFILL && flush) begin
            r_flush_pend <= 1'b1;
         end
         if (w_fill_done && !r_flush_pend && !flush) begin
            r_valid[w_fill_idx] <= 1'b1;
         end
         if (flush) begin
            r_valid <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_beat_we) begin
         r_data[w_fill_idx][r_beat] <= bus.icresp_data;
      end
      if (w_fill_done) begin
         r_tag[w_fill_idx] <= r_addr[31 -: c_TAG_W];
      end
   end

`ifdef ICACHE_PERF_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_miss_start) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt  = r_hit_cnt;
   assign miss_cnt = r_miss_cnt;
`else
   assign hit_cnt  = 32'd0;
   assign miss_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_icache_dm.sv
`default_nettype none
// tb_icache_dm: directed fetch sequence against a CBus memory model; expected
// fetch data is queued when a request is issued and compared at data_ok.
module tb_icache_dm;
   localparam int         WPL        = 8;
   localparam logic [1:0] BURST_INCR = 2'd1;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   icache_dm_if bus ();

   icache_dm #(.NUM_LINES(16), .WORDS_PER_LINE(WPL), .UNCACHED_BIT(31)) dut (
      .clk(clk), .reset(reset), .bus(bus), .flush(flush),
      .hit_cnt(hit_cnt), .miss_cnt(miss_cnt));

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_err = 0;
   logic [31:0] exp_q [$];
   int          beat = 0, stall_beat = -1, stall_left = 0, flush_beat = -1, reset_beat = -1;
   int          n_txn = 0, exp_hits = 0, exp_miss = 0, lat = 0;
   bit          in_req = 0, got_ok = 0, did_reset = 0, rst_seen = 0, flush_idle = 0;
   logic [63:0] unc_data = '0;
   logic [63:0] held = '0;

   function automatic logic [63:0] mem64(input logic [31:0] a);
      return 64'h1111_0000_2222_0000 + 64'(a[15:3]);
   endfunction

   function automatic logic [31:0] half(input logic [63:0] d, input logic [31:0] a);
      return a[2] ? d[63:32] : d[31:0];
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic fail_now(input string tag, input logic [31:0] info);
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed none expected event (addr 0x%0h)", tag, info);
   endtask

   task automatic check_cnt();
`ifdef ICACHE_PERF_EN
      check("hit_cnt", hit_cnt, 64'(exp_hits));
      check("miss_cnt", miss_cnt, 64'(exp_miss));
`else
      check("hit_cnt", hit_cnt, 64'd0);
      check("miss_cnt", miss_cnt, 64'd0);
`endif
   endtask

   // One clock of memory model + response checking; entered and left at negedge
   task automatic cycle();
      logic        cacheable;
      logic [31:0] lb;
      logic [63:0] fields;
      bus.icresp_ready = 1'b0;
      bus.icresp_last  = 1'b0;
      bus.icresp_data  = '0;
      flush            = flush_idle;
      reset            = 1'b0;
      did_reset        = 0;
      cacheable        = bus.ireq_addr[31];
      lb               = {bus.ireq_addr[31:6], 6'b0};
      if (bus.icreq_valid) begin
         fields = {14'b0, bus.icreq_addr, bus.icreq_size, bus.icreq_len, bus.icreq_burst,
                   bus.icreq_is_write, bus.icreq_strobe};
         if (!in_req) begin
            in_req = 1;
            beat   = 0;
            held   = fields;
            if (cacheable) exp_miss++;
            check("req_addr", bus.icreq_addr, cacheable ? lb : bus.ireq_addr);
            check("req_size", bus.icreq_size, cacheable ? 3'd3 : 3'd2);
            check("req_len", bus.icreq_len, cacheable ? 4'(WPL - 1) : 4'd0);
            check("req_burst", bus.icreq_burst, cacheable ? 2'd1 : 2'd0);
            check("req_rd", {bus.icreq_is_write, bus.icreq_strobe}, 64'd0);
         end else begin
            check("req_hold", fields, held);
         end
         if (beat == stall_beat && stall_left > 0) begin
            stall_left--;
         end else begin
            bus.icresp_ready = 1'b1;
            bus.icresp_data  = cacheable ? mem64(lb + 32'(beat) * 32'd8) : unc_data;
            bus.icresp_last  = cacheable ? (beat == WPL - 1) : 1'b1;
            if (beat == flush_beat) begin
               flush      = 1'b1;
               flush_beat = -1;
            end
            if (beat == reset_beat) begin
               reset      = 1'b1;
               reset_beat = -1;
               did_reset  = 1;
               rst_seen   = 1;
            end
         end
      end
      #1;
      if (bus.iresp_data_ok) begin
         got_ok = 1;
         check("addr_ok", bus.iresp_addr_ok, 64'd1);
         check("ok_in_refill", bus.icreq_valid && (bus.icreq_burst == BURST_INCR), 64'd0);
         if (exp_q.size() == 0) fail_now("unexpected_ok", bus.ireq_addr);
         else check("data", bus.iresp_data, exp_q.pop_front());
      end else begin
         check("iresp_zero", {bus.iresp_addr_ok, bus.iresp_data}, 64'd0);
      end
      @(posedge clk);
      if (bus.icresp_ready) begin
         beat++;
         if (bus.icresp_last) begin
            in_req = 0;
            n_txn++;
         end
      end
      if (did_reset) begin
         in_req   = 0;
         exp_hits = 0;
         exp_miss = 0;
      end
      @(negedge clk);
   endtask

   task automatic fetch(input logic [31:0] a, input int exp_lat, input int exp_txn);
      int txn0;
      txn0            = n_txn;
      bus.ireq_valid  = 1'b1;
      bus.ireq_addr   = a;
      exp_q.push_back(a[31] ? half(mem64(a), a) : half(unc_data, a));
      got_ok          = 0;
      lat             = -1;
      for (int c = 0; c < 64 && !got_ok; c++) begin
         cycle();
         if (got_ok) lat = c;
      end
      bus.ireq_valid = 1'b0;
      if (!got_ok) begin
         fail_now("fetch_timeout", a);
         exp_q.delete();
      end else if (a[31]) begin
         exp_hits++;
      end
      check("latency", 64'(lat), 64'(exp_lat));
      check("txn_count", 64'(n_txn - txn0), 64'(exp_txn));
   endtask

   initial begin
      reset            = 1'b1;
      flush            = 1'b0;
      bus.ireq_valid   = 1'b0;
      bus.ireq_addr    = '0;
      bus.icresp_ready = 1'b0;
      bus.icresp_last  = 1'b0;
      bus.icresp_data  = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_icreq_valid", bus.icreq_valid, 64'd0);
      check("rst_iresp", {bus.iresp_addr_ok, bus.iresp_data_ok, bus.iresp_data}, 64'd0);
      check_cnt();
      @(negedge clk);

      // cold miss, hit on the other half, conflict misses on index 0
      fetch(32'h8000_0000, 9, 1);
      fetch(32'h8000_0004, 0, 0);
      fetch(32'h8000_0400, 9, 1);
      fetch(32'h8000_0000, 9, 1);
      check_cnt();

      // uncached fetches never allocate
      unc_data = 64'hDEAD_BEEF_0000_0000;
      fetch(32'h1000_0004, 1, 1);
      fetch(32'h1000_0004, 1, 1);
      unc_data = 64'h0123_4567_89AB_CDEF;
      fetch(32'h1000_0000, 1, 1);

      // flush in IDLE: same-cycle hit still served, then line gone
      flush_idle = 1;
      fetch(32'h8000_0000, 0, 0);
      flush_idle = 0;
      fetch(32'h8000_0000, 9, 1);

      // flush on 3rd beat: line not kept, held request refills again
      flush_beat = 2;
      fetch(32'h8000_0100, 18, 2);
      fetch(32'h8000_010C, 0, 0);

      // backpressure: ready low 5 cycles before beat 3, then all words hit
      stall_beat = 3;
      stall_left = 5;
      fetch(32'h8000_0200, 14, 1);
      stall_beat = -1;
      for (int i = 0; i < WPL; i++) fetch(32'h8000_0200 + 32'(i * 8 + (i % 2) * 4), 0, 0);
      check_cnt();

      // reset pulse on the 4th beat abandons the refill
      bus.ireq_valid = 1'b1;
      bus.ireq_addr  = 32'h8000_0240;
      reset_beat     = 3;
      for (int c = 0; c < 32 && !rst_seen; c++) cycle();
      if (!rst_seen) fail_now("reset_not_applied", 32'h8000_0240);
      reset_beat = -1;
      #1;
      check("rst_mid_icreq_valid", bus.icreq_valid, 64'd0);
      check("rst_mid_data_ok", bus.iresp_data_ok, 64'd0);
      reset          = 1'b0;
      bus.ireq_valid = 1'b0;
      @(negedge clk);
      check_cnt();
      fetch(32'h8000_0240, 9, 1);
      fetch(32'h8000_0200, 9, 1);
      check_cnt();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
